// File: rtl/sl3_tx_arbiter_pkg.sv
// sl3_tx_arbiter_pkg: DTEngine line type, device-id width and arbiter states
// shared by the SL3 TX arbiter and its skid buffer.
package sl3_tx_arbiter_pkg;
    localparam int DEVICE_ID_WIDTH = 4;
    localparam int PAYLOAD_W       = 32;

    typedef struct packed {
        logic                 last;
        logic [PAYLOAD_W-1:0] payload;
    } CoreDataIn;

    typedef struct packed {
        CoreDataIn                  line;
        logic [DEVICE_ID_WIDTH-1:0] addr;
    } tx_entry_t;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/sl3_tx_skid_buf.sv
// sl3_tx_skid_buf: 2-entry registered buffer for {CoreDataIn, addr}; ready depends
// only on occupancy, so nothing upstream sees out_ready combinationally.
module sl3_tx_skid_buf
    import sl3_tx_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_valid,
    output logic      o_ready,
    input  tx_entry_t i_data,
    output logic      o_valid,
    input  logic      i_ready,
    output tx_entry_t o_data,
    output logic      o_empty
);
    tx_entry_t  r_mem [2];
    logic       r_wr;
    logic       r_rd;
    logic [1:0] r_cnt;
    logic       w_push;
    logic       w_pop;

    assign o_ready = r_cnt != 2'd2;
    assign o_valid = r_cnt != 2'd0;
    assign o_empty = r_cnt == 2'd0;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push)
                r_mem[r_wr] <= i_data;
            r_wr  <= r_wr ^ w_push;
            r_rd  <= r_rd ^ w_pop;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/sl3_tx_arbiter.sv
// sl3_tx_arbiter: round-robin SL3 TX arbiter with burst lock per destination.
// Optional perf counters enabled by SL3_ARB_PERF_CNT_EN.
module sl3_tx_arbiter
    import sl3_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int REQ_BITS = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_arb_enable,
    input  logic [15:0]                i_max_burst_minus_one,
    input  CoreDataIn                  i_req_data [NUM_REQ],
    input  logic [DEVICE_ID_WIDTH-1:0] i_req_addr [NUM_REQ],
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output CoreDataIn                  o_out_data,
    output logic [DEVICE_ID_WIDTH-1:0] o_out_addr,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [REQ_BITS-1:0]        o_grant_id,
    output logic                       o_busy,
    output logic [31:0]                o_perf_lines [NUM_REQ],
    output logic [31:0]                o_perf_stall
);
    arb_state_t                 r_state;
    logic [REQ_BITS-1:0]        r_grant_id;
    logic [DEVICE_ID_WIDTH-1:0] r_lock_addr;
    logic [15:0]                r_burst_cnt;
    logic [REQ_BITS-1:0]        w_pick;
    logic [REQ_BITS-1:0]        w_idx;
    logic                       w_any;
    logic                       w_own_valid;
    logic                       w_addr_ok;
    logic                       w_buf_ready;
    logic                       w_buf_empty;
    logic                       w_acc;
    CoreDataIn                  w_own_line;
    tx_entry_t                  w_buf_in;
    tx_entry_t                  w_buf_out;

    assign w_own_line  = i_req_data[r_grant_id];
    assign w_own_valid = i_req_valid[r_grant_id];
    assign w_addr_ok   = i_req_addr[r_grant_id] == r_lock_addr;
    assign w_acc       = (r_state == ARB_GRANT) & w_own_valid & w_addr_ok & w_buf_ready;
    assign w_buf_in    = {w_own_line, i_req_addr[r_grant_id]};

    // Scan downwards so the last hit is the first valid index after the previous owner.
    always_comb begin
        w_pick = r_grant_id;
        w_idx  = r_grant_id;
        w_any  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = REQ_BITS'((int'(r_grant_id) + k) % NUM_REQ);
            if (i_req_valid[w_idx]) begin
                w_pick = w_idx;
                w_any  = 1'b1;
            end
        end
    end

    // A line for a different destination is refused, so ready also needs an address match.
    always_comb begin
        o_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            o_req_ready[i] = (r_state == ARB_GRANT) && (r_grant_id == REQ_BITS'(i)) && w_buf_ready && w_addr_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_grant_id  <= '0;
            r_lock_addr <= '0;
            r_burst_cnt <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (i_arb_enable && w_any) begin
                r_state     <= ARB_GRANT;
                r_grant_id  <= w_pick;
                r_lock_addr <= i_req_addr[w_pick];
                r_burst_cnt <= '0;
            end
        end else if (w_own_valid && !w_addr_ok) begin
            r_state <= ARB_IDLE;
        end else if (w_acc) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
            if (r_burst_cnt == i_max_burst_minus_one || w_own_line.last)
                r_state <= ARB_IDLE;
        end
    end

    sl3_tx_skid_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_acc),
        .o_ready (w_buf_ready),
        .i_data  (w_buf_in),
        .o_valid (o_out_valid),
        .i_ready (i_out_ready),
        .o_data  (w_buf_out),
        .o_empty (w_buf_empty)
    );

    assign o_out_data = w_buf_out.line;
    assign o_out_addr = w_buf_out.addr;
    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state == ARB_GRANT) | ~w_buf_empty;

`ifdef SL3_ARB_PERF_CNT_EN
    logic [31:0] r_perf_lines [NUM_REQ];
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++)
                r_perf_lines[i] <= '0;
            r_perf_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (w_acc && r_grant_id == REQ_BITS'(i) && r_perf_lines[i] != '1)
                    r_perf_lines[i] <= r_perf_lines[i] + 32'd1;
            if (o_out_valid && !i_out_ready && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign o_perf_lines = r_perf_lines;
    assign o_perf_stall = r_perf_stall;
`else
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            o_perf_lines[i] = '0;
    end
    assign o_perf_stall = '0;
`endif
endmodule
